// File: rtl/bbox_mem_pkg.sv
// bbox_mem_pkg: shared widths and request/response record types for the
// bbox_mem node-bbox-pair fetch unit and the logic that talks to it.
package bbox_mem_pkg;

  localparam int ID_WIDTH      = 5;
  localparam int NBP_IDX_WIDTH = 29;
  localparam int NBP_BYTES     = 56;
  localparam int NBP_WIDTH     = NBP_BYTES * 8;

  typedef logic [NBP_IDX_WIDTH-1:0] nbp_idx_t;
  typedef logic [NBP_WIDTH-1:0]     nbp_t;

  typedef struct packed {
    nbp_idx_t            nbp_idx;
    logic [ID_WIDTH-1:0] id;
  } bbox_mem_req_t;

  typedef struct packed {
    nbp_t                nbp;
    logic [ID_WIDTH-1:0] id;
  } bbox_mem_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant. The search starts just after the
// most recent winner, so every active requester is served within N grants.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] last
);

  logic [W-1:0] cand;
  logic         found;

  // Cyclic search from last+1; N is a power of two so the index wraps for free.
  always_comb begin
    gnt   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = last + W'(k);
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Remember the winner; the pointer starts at N-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= W'(N - 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) last <= W'(i);
      end
    end
  end

endmodule

// File: rtl/bbox_mem_arb.sv
// bbox_mem_arb: shares the single bbox_mem NBP fetch unit among NUM_REQ
// traversal requesters. Requests are tagged with the requester index in the
// upper ID bits; responses are routed back by that same tag.
// Optional statistics counters are built when BBOX_MEM_ARB_STATS_EN is defined.
module bbox_mem_arb #(
  parameter int NUM_REQ        = 4,
  parameter int SEL_WIDTH      = $clog2(NUM_REQ),
  parameter int ID_WIDTH       = bbox_mem_pkg::ID_WIDTH,
  parameter int LOCAL_ID_WIDTH = ID_WIDTH - SEL_WIDTH,
  parameter int NBP_IDX_WIDTH  = bbox_mem_pkg::NBP_IDX_WIDTH,
  parameter int NBP_WIDTH      = bbox_mem_pkg::NBP_WIDTH
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,
  input  logic [NUM_REQ*(NBP_IDX_WIDTH+LOCAL_ID_WIDTH)-1:0] req_din,
  input  logic [NUM_REQ-1:0]                            req_empty,
  output logic [NUM_REQ-1:0]                            req_read,
  output logic [ID_WIDTH+NBP_IDX_WIDTH-1:0]             bbox_mem_req_din,
  output logic                                          bbox_mem_req_empty,
  input  logic                                          bbox_mem_req_read,
  input  logic [ID_WIDTH+NBP_WIDTH-1:0]                 bbox_mem_resp_dout,
  input  logic                                          bbox_mem_resp_write,
  output logic                                          bbox_mem_resp_full,
  output logic [NBP_WIDTH+LOCAL_ID_WIDTH-1:0]           resp_din,
  output logic [NUM_REQ-1:0]                            resp_write,
  input  logic [NUM_REQ-1:0]                            resp_full
`ifdef BBOX_MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]                         grant_cnt,
  output logic [31:0]                                   resp_stall_cnt
`endif
);

  localparam int REQ_W = NBP_IDX_WIDTH + LOCAL_ID_WIDTH;
  localparam int RS_W  = NBP_WIDTH + LOCAL_ID_WIDTH;

  logic                 refill;
  logic                 arb_en;
  logic [SEL_WIDTH-1:0] last;
  logic [REQ_W-1:0]     gnt_data;
  logic                 rq_valid;
  logic [REQ_W-1:0]     rq_data;

  logic                 drain;
  logic                 capture;
  logic                 rs_valid;
  logic [SEL_WIDTH-1:0] rs_sel;
  logic [RS_W-1:0]      rs_data;

  // The slot can take a new request when empty or being popped this cycle.
  // Grants are suppressed while reset is held so no requester FIFO is popped.
  assign refill = !rq_valid || bbox_mem_req_read;
  assign arb_en = refill && aresetn;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk   (aclk),
    .rst_n (aresetn),
    .req   (~req_empty),
    .en    (arb_en),
    .gnt   (req_read),
    .last  (last)
  );

  // Select the granted requester's {nbp_idx, local_id} with the one-hot grant.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_read[i]) gnt_data = req_din[i*REQ_W +: REQ_W];
    end
  end

  // Request slot: loads on every grant, empties when popped with nothing new.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rq_valid <= 1'b0;
      rq_data  <= '0;
    end else if (refill) begin
      rq_valid <= |req_read;
      if (|req_read) rq_data <= gnt_data;
    end
  end

  // The slot is loaded only on a grant and the pointer moves only on a grant,
  // so the pointer always holds the index of the requester in the slot.
  assign bbox_mem_req_din   = {rq_data[REQ_W-1:LOCAL_ID_WIDTH], last,
                               rq_data[LOCAL_ID_WIDTH-1:0]};
  assign bbox_mem_req_empty = !rq_valid;

  assign drain              = rs_valid && !resp_full[rs_sel];
  assign bbox_mem_resp_full = rs_valid && !drain;
  assign capture            = bbox_mem_resp_write && !bbox_mem_resp_full;
  assign resp_write         = drain ? (NUM_REQ'(1) << rs_sel) : '0;
  assign resp_din           = rs_data;

  // Response slot: capture strips the requester tag, drain empties it unless
  // a new response lands in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rs_valid <= 1'b0;
      rs_sel   <= '0;
      rs_data  <= '0;
    end else if (capture) begin
      rs_valid <= 1'b1;
      rs_sel   <= bbox_mem_resp_dout[ID_WIDTH-1:LOCAL_ID_WIDTH];
      rs_data  <= {bbox_mem_resp_dout[ID_WIDTH+NBP_WIDTH-1:ID_WIDTH],
                   bbox_mem_resp_dout[LOCAL_ID_WIDTH-1:0]};
    end else if (drain) begin
      rs_valid <= 1'b0;
    end
  end

`ifdef BBOX_MEM_ARB_STATS_EN
  // Saturating per-requester grant counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_read[i] && (grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF))
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end

  // Saturating count of cycles a held response waits on a full requester.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      resp_stall_cnt <= '0;
    end else if (rs_valid && resp_full[rs_sel] && (resp_stall_cnt != 32'hFFFF_FFFF)) begin
      resp_stall_cnt <= resp_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
